// File: rtl/attn_value_mac_if.sv
// Purpose: handshake/bus bundle between attn_value_mac and its driver/consumer.
// Latency: none, wires only.
// Backpressure: carries p_valid/p_ready and out_valid/out_ready pairs unchanged.
interface attn_value_mac_if #(
  parameter int PROB_WIDTH = 32,
  parameter int VAL_WIDTH  = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int SEQ_LEN    = 64,
  parameter int D_MODEL    = 64
);
  localparam int ROW_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int COL_W = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;

  logic                         start;
  logic                         v_wr_en;
  logic [ROW_W-1:0]             v_wr_row;
  logic [COL_W-1:0]             v_wr_col;
  logic [VAL_WIDTH-1:0]         v_wr_data;
  logic                         p_valid;
  logic [PROB_WIDTH-1:0]        p_data;
  logic                         p_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [D_MODEL*OUT_WIDTH-1:0] out_data;
  logic [ROW_W-1:0]             out_row;
  logic                         busy;
  logic                         done;

  modport master (
    output start, v_wr_en, v_wr_row, v_wr_col, v_wr_data, p_valid, p_data, out_ready,
    input  p_ready, out_valid, out_data, out_row, busy, done
  );

  modport slave (
    input  start, v_wr_en, v_wr_row, v_wr_col, v_wr_data, p_valid, p_data, out_ready,
    output p_ready, out_valid, out_data, out_row, busy, done
  );
endinterface

// File: rtl/attn_value_mac.sv
// Purpose: out[i][d] = sat((sum_k P[i][k]*V[k][d]) >>> FRAC_BITS); define ATTN_ROUND_EN for round-half-up.
// Latency: one probability per cycle per row; out_valid the cycle after the SEQ_LEN-th accept.
// Backpressure: a stalled output row holds its data and keeps p_ready low until out_ready.
module attn_value_mac #(
  parameter int PROB_WIDTH = 32,
  parameter int VAL_WIDTH  = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int SEQ_LEN    = 64,
  parameter int D_MODEL    = 64,
  parameter int FRAC_BITS  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  attn_value_mac_if.slave bus
);
  localparam int ROW_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int PRD_W = PROB_WIDTH + VAL_WIDTH + 1;
  // One bit of headroom per doubling of SEQ_LEN keeps the running sum from wrapping.
  localparam int ACC_W = PRD_W + $clog2(SEQ_LEN);
  localparam logic [ROW_W-1:0] LAST = ROW_W'(SEQ_LEN - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX_A = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN_A = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`ifdef ATTN_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = (FRAC_BITS > 0) ? (ACC_W'(1) << (FRAC_BITS - 1)) : '0;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT, DONE} state_t;

  state_t                      state, state_nxt;
  logic [ROW_W-1:0]            row, k;
  logic                        run_go, accept, row_adv, acc_clr;
  logic signed [VAL_WIDTH-1:0] v_mem [SEQ_LEN][D_MODEL];
  logic signed [PROB_WIDTH:0]  p_ext;
  logic signed [PRD_W-1:0]     p_w;
  logic [D_MODEL*OUT_WIDTH-1:0] out_flat;

  // Probabilities are unsigned; a zero MSB makes them safe signed multiplicands.
  assign p_ext = {1'b0, bus.p_data};
  assign p_w   = PRD_W'(p_ext);

  assign bus.p_ready   = (state == ACCUM);
  assign bus.out_valid = (state == OUTPUT);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.out_row   = row;
  assign bus.out_data  = out_flat;
  assign acc_clr       = run_go | row_adv;

  // Next state plus the per-cycle control strobes that steer counters and accumulators.
  always_comb begin
    state_nxt = state;
    run_go    = 1'b0;
    accept    = 1'b0;
    row_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          run_go    = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.p_valid) begin
          accept = 1'b1;
          if (k == LAST) state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          if (row == LAST) begin
            state_nxt = DONE;
          end else begin
            row_adv   = 1'b1;
            state_nxt = ACCUM;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with row and k counters; reset abandons any run in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      if (run_go) begin
        row <= '0;
        k   <= '0;
      end else if (accept) begin
        k <= k + ROW_W'(1);
      end else if (row_adv) begin
        row <= row + ROW_W'(1);
        k   <= '0;
      end
    end
  end

  // V is only writable while idle and deliberately has no reset so it survives rst_n.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.v_wr_en) v_mem[bus.v_wr_row][bus.v_wr_col] <= bus.v_wr_data;
  end

  for (genvar d = 0; d < D_MODEL; d++) begin : g_col
    logic signed [ACC_W-1:0]     acc, biased, shifted;
    logic signed [PRD_W-1:0]     prod;
    logic signed [OUT_WIDTH-1:0] sat;

    assign prod = p_w * PRD_W'(v_mem[k][d]);
`ifdef ATTN_ROUND_EN
    assign biased = acc + RND;
`else
    assign biased = acc;
`endif
    assign shifted = biased >>> FRAC_BITS;
    assign out_flat[d*OUT_WIDTH +: OUT_WIDTH] = sat;

    // Clamp the scaled sum into the signed output range.
    always_comb begin
      sat = shifted[OUT_WIDTH-1:0];
      if (shifted > OUT_MAX_A)      sat = OUT_MAX;
      else if (shifted < OUT_MIN_A) sat = OUT_MIN;
    end

    // Clear at run or row start, then add one P*V term per accepted probability.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       acc <= '0;
      else if (acc_clr) acc <= '0;
      else if (accept)  acc <= acc + ACC_W'(prod);
    end
  end
endmodule

// File: tb/tb_attn_value_mac.sv
// Purpose: randomized and directed stimulus for attn_value_mac, scoreboard-checked output rows.
// Latency: expected rows are queued after each row's last probability and popped on handshake.
// Backpressure: out_ready is forced high, random, or held low depending on the scenario.
module tb_attn_value_mac;
  localparam int PW = 32;
  localparam int VW = 32;
  localparam int OW = 16;
  localparam int SL = 4;
  localparam int DM = 4;
  localparam int FB = 8;
  localparam int IW = 2;
  localparam longint OMAX = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint OMIN = -(longint'(1) <<< (OW - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  attn_value_mac_if #(.PROB_WIDTH(PW), .VAL_WIDTH(VW), .OUT_WIDTH(OW),
                      .SEQ_LEN(SL), .D_MODEL(DM)) bus ();

  attn_value_mac #(.PROB_WIDTH(PW), .VAL_WIDTH(VW), .OUT_WIDTH(OW),
                   .SEQ_LEN(SL), .D_MODEL(DM), .FRAC_BITS(FB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [IW-1:0]         row;
    logic [DM-1:0][63:0]   d;
  } exp_t;

  exp_t   sbq[$];
  longint vm[SL][DM];
  longint pm[SL][SL];
  int     errs = 0;
  int     checks = 0;
  int     rdy_mode = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d", name, act, expv);
    end
  endtask

  task automatic bail(input string name);
    errs++;
    checks++;
    $display("FAIL %s: no DUT response within bound, required a response", name);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  endtask

  // Reference: exact integer dot product, optional half-LSB bias, floor division, clamp.
  function automatic longint ref_out(input int i, input int d);
    longint s, q, div;
    s = 0;
    div = longint'(1) << FB;
    for (int kk = 0; kk < SL; kk++) s += pm[i][kk] * vm[kk][d];
`ifdef ATTN_ROUND_EN
    s += div / 2;
`endif
    q = s / div;
    if ((s % div) != 0 && s < 0) q = q - 1;
    if (q > OMAX) q = OMAX;
    if (q < OMIN) q = OMIN;
    return q;
  endfunction

  function automatic longint rand_v();
    int x;
    x = $urandom;
    return longint'(x >>> $urandom_range(8, 28));
  endfunction

  function automatic longint rand_p();
    if ($urandom_range(0, 7) == 0) return longint'($urandom);
    return longint'($urandom_range(0, 600));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input int i);
    exp_t e;
    e.row = IW'(i);
    for (int d = 0; d < DM; d++) e.d[d] = ref_out(i, d);
    sbq.push_back(e);
  endtask

  // Scoreboard monitor: one expected row per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          errs++;
          checks++;
          $display("FAIL unexpected_row: got row %0d, required no output", bus.out_row);
        end else begin
          e = sbq.pop_front();
          chk("out_row", 64'(bus.out_row), 64'(e.row));
          for (int d = 0; d < DM; d++)
            chk($sformatf("out_data_r%0d_d%0d", e.row, d),
                64'($signed(bus.out_data[d*OW +: OW])), e.d[d]);
        end
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_p_ready"}, 64'(bus.p_ready), 0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 0);
    chk({tag, "_busy"}, 64'(bus.busy), 0);
    chk({tag, "_done"}, 64'(bus.done), 0);
    chk({tag, "_out_row"}, 64'(bus.out_row), 0);
    for (int d = 0; d < DM; d++)
      chk($sformatf("%s_out_data%0d", tag, d), 64'($signed(bus.out_data[d*OW +: OW])), 0);
  endtask

  task automatic wr_v(input int r, input int c, input longint val);
    bus.v_wr_en   = 1'b1;
    bus.v_wr_row  = IW'(r);
    bus.v_wr_col  = IW'(c);
    bus.v_wr_data = VW'(val);
    vm[r][c] = val;
    tick();
    bus.v_wr_en = 1'b0;
  endtask

  task automatic start_run(input bit with_wr);
    int r, c;
    longint val;
    bus.start = 1'b1;
    if (with_wr) begin
      r = $urandom_range(0, SL - 1);
      c = $urandom_range(0, DM - 1);
      val = rand_v();
      bus.v_wr_en   = 1'b1;
      bus.v_wr_row  = IW'(r);
      bus.v_wr_col  = IW'(c);
      bus.v_wr_data = VW'(val);
      vm[r][c] = val;
    end
    tick();
    bus.start   = 1'b0;
    bus.v_wr_en = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 1);
  endtask

  task automatic send_row(input int i, input int nk, input bit noisy);
    bit took;
    int guard;
    for (int kk = 0; kk < nk; kk++) begin
      took = 1'b0;
      guard = 0;
      while (!took) begin
        bus.p_valid = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.p_data  = PW'(pm[i][kk]);
        if (noisy && $urandom_range(0, 2) == 0) begin
          bus.v_wr_en   = 1'b1;
          bus.v_wr_row  = IW'($urandom_range(0, SL - 1));
          bus.v_wr_col  = IW'($urandom_range(0, DM - 1));
          bus.v_wr_data = $urandom;
        end
        if (noisy && $urandom_range(0, 3) == 0) bus.start = 1'b1;
        @(negedge clk);
        took = bus.p_valid && bus.p_ready;
        if (took) chk("out_valid_low_in_accum", 64'(bus.out_valid), 0);
        tick();
        bus.p_valid = 1'b0;
        bus.v_wr_en = 1'b0;
        bus.start   = 1'b0;
        guard++;
        if (guard > 300) bail("p_accept_timeout");
      end
    end
    if (nk == SL) begin
      push_row(i);
      chk($sformatf("out_valid_after_last_accept_r%0d", i), 64'(bus.out_valid), 1);
    end
  endtask

  task automatic wait_done();
    int seen, t;
    seen = 0;
    t = 0;
    while (seen == 0) begin
      @(negedge clk);
      t++;
      if (bus.done) seen = 1;
      if (t > 300) bail("done_timeout");
    end
    chk("busy_with_done", 64'(bus.busy), 1);
    tick();
    chk("done_one_cycle", 64'(bus.done), 0);
    chk("busy_drops_after_done", 64'(bus.busy), 0);
    chk("rows_drained", 64'(sbq.size()), 0);
  endtask

  task automatic full_run(input bit noisy, input bit with_wr);
    start_run(with_wr);
    for (int i = 0; i < SL; i++) send_row(i, SL, noisy);
    wait_done();
  endtask

  initial begin
    logic [DM*OW-1:0] snap;
    bus.start = 1'b0;
    bus.v_wr_en = 1'b0;
    bus.v_wr_row = '0;
    bus.v_wr_col = '0;
    bus.v_wr_data = '0;
    bus.p_valid = 1'b0;
    bus.p_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Identity V scaled by 256: row 0 with all-64 probabilities must come back as 64s.
    for (int r = 0; r < SL; r++)
      for (int c = 0; c < DM; c++) wr_v(r, c, (r == c) ? 256 : 0);
    for (int i = 0; i < SL; i++)
      for (int kk = 0; kk < SL; kk++) pm[i][kk] = (i == 0) ? 64 : rand_p();
    full_run(1'b0, 1'b0);

    // Backpressure on row 0: held output, p_ready low, offered probability not taken.
    for (int r = 0; r < SL; r++)
      for (int c = 0; c < DM; c++) wr_v(r, c, rand_v());
    for (int i = 0; i < SL; i++)
      for (int kk = 0; kk < SL; kk++) pm[i][kk] = rand_p();
    rdy_mode = 2;
    start_run(1'b0);
    send_row(0, SL, 1'b0);
    snap = bus.out_data;
    bus.p_valid = 1'b1;
    bus.p_data = PW'(pm[1][0]);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(bus.out_valid), 1);
      chk("stall_p_ready", 64'(bus.p_ready), 0);
      chk("stall_out_data_stable", 64'(bus.out_data == snap), 1);
    end
    rdy_mode = 0;
    tick();
    @(negedge clk);
    chk("stall_release_valid", 64'(bus.out_valid), 1);
    tick();
    chk("row1_accum_p_ready", 64'(bus.p_ready), 1);
    chk("row1_out_row", 64'(bus.out_row), 1);
    for (int i = 1; i < SL; i++) send_row(i, SL, 1'b0);
    wait_done();

    // Saturation at both ends of the 16-bit output range.
    for (int r = 0; r < SL; r++)
      for (int c = 0; c < DM; c++) wr_v(r, c, 32767);
    for (int i = 0; i < SL; i++)
      for (int kk = 0; kk < SL; kk++) pm[i][kk] = 256;
    full_run(1'b0, 1'b0);
    for (int r = 0; r < SL; r++)
      for (int c = 0; c < DM; c++) wr_v(r, c, -32768);
    full_run(1'b0, 1'b0);

    // Rounding boundary: a single half-LSB contribution in row 0.
    for (int r = 0; r < SL; r++)
      for (int c = 0; c < DM; c++) wr_v(r, c, (r == 0) ? 128 : rand_v());
    for (int i = 0; i < SL; i++)
      for (int kk = 0; kk < SL; kk++) pm[i][kk] = (i == 0) ? ((kk == 0) ? 1 : 0) : rand_p();
    full_run(1'b0, 1'b0);

    // Reset after two accepts of row 1, then a clean rerun with the surviving V.
    for (int r = 0; r < SL; r++)
      for (int c = 0; c < DM; c++) wr_v(r, c, rand_v());
    for (int i = 0; i < SL; i++)
      for (int kk = 0; kk < SL; kk++) pm[i][kk] = rand_p();
    start_run(1'b0);
    send_row(0, SL, 1'b0);
    send_row(1, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    chk("midrun_queue_empty", 64'(sbq.size()), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    full_run(1'b0, 1'b0);

    // Randomized runs with gaps, random ready, ignored writes/starts, start+write collisions.
    rdy_mode = 1;
    for (int run = 0; run < 6; run++) begin
      for (int r = 0; r < SL; r++)
        for (int c = 0; c < DM; c++) wr_v(r, c, rand_v());
      for (int i = 0; i < SL; i++)
        for (int kk = 0; kk < SL; kk++) pm[i][kk] = rand_p();
      full_run(1'b1, run[0]);
    end
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #400000;
    bail("global_timeout");
  end
endmodule
